exe_alu_arbiter: RTL
====================

Name: exe_alu_arbiter

Overview:
- Shares the single combinational execute-stage ALU between two requesters: port 0 (main pipeline issue) and port 1 (auxiliary unit, e.g. CSR/address calculation).
- Round-robin arbitration, one issue register feeding the ALU, and a 2-entry response FIFO.
- Sits between issue logic and exe_stage_alu. Full throughput of one operation per cycle when the response side is not stalled.

Parameters:
- XLEN, 64, operand/result width (matches REG_BUS)
- ALU_W, 10, one-hot ALU op width (matches ALU_BUS)
- BJ_W, 8, branch-condition vector width (matches BJ_BUS)
- TAG_W, 5, requester-private tag width, returned unchanged

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- flush  in  1  drop all in-flight operations
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op1, req0_op2, req1_op1, req1_op2  in  XLEN  operands
- req0_alu_info / req1_alu_info  in  ALU_W  one-hot op
- req0_word / req1_word  in  1  32-bit word op
- req0_tag / req1_tag  in  TAG_W  tag
- alu_op1, alu_op2  out  XLEN  to ALU, driven from issue register
- alu_info  out  ALU_W  to ALU; all-zero when issue register empty
- alu_word  out  1  to ALU is_word_opt
- alu_output  in  XLEN  ALU result
- alu_bj  in  BJ_W  ALU branch conditions
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  1  originating requester
- rsp_tag  out  TAG_W  originating tag
- rsp_data  out  XLEN  result
- rsp_bj  out  BJ_W  branch conditions

Behaviour:
- Reset (rst==0 at posedge):
  - issue valid=0, FIFO count=0, rr pointer=0.
  - All outputs 0 while in and after reset, until the first accept.
- Stages:
  - Accept at cycle T: operands, info, word, tag and id load into the issue register.
  - Cycle T+1: ALU evaluates combinationally; at the end of T+1 the result is written to the FIFO tail with id/tag.
  - rsp_valid rises in T+2. Minimum latency is 2 cycles.
- Issue advance: adv = iss_valid & (count<2 | (rsp_valid & rsp_ready)).
- Slot free: free = ~iss_valid | adv.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the rr pointer.
  - reqN_ready = grantN & free & ~flush. At most one ready is high per cycle.
  - Ready depends combinationally on reqN_valid; valid must not depend on ready.
- rr pointer updates only on an accepted transfer: pointer becomes the other requester (~granted id). With no accept it holds.
- FIFO: 2 entries, circular read/write pointers, count 0..2.
  - Push (adv) and pop (rsp_valid & rsp_ready) in the same cycle leave count unchanged. This is legal at count==2 because the pop frees a slot.
  - No push while full without a pop.
- Response outputs show the head entry. They stay stable while rsp_valid & ~rsp_ready.
- Word ops: the result is taken as produced by the ALU (already sign-extended). No re-extension here.
- flush=1 at posedge:
  - Clears iss_valid and FIFO count/pointers. No accept that cycle.
  - rr pointer unchanged.
  - rsp_valid is 0 the next cycle.
  - flush takes precedence over simultaneous push/pop.
- Reset has priority over flush.
- Reset mid-operation discards everything, identical to the power-up state.

Test Plan:
- Single op, port 0 ADD op1=5 op2=7: accepted at T, rsp_valid at T+2 with rsp_data=12, rsp_id=0, tag echoed; rsp_ready=1 empties the FIFO at T+3.
- Both ports valid every cycle, rsp_ready=1: grants alternate 0,1,0,1 starting at port 0 after reset; one response per cycle, in grant order.
- Backpressure: rsp_ready=0 with 4 requests from port 1 (SUB 10-3, 9-1, 8-8, 1-2) → 2 in FIFO, 1 in issue, req1_ready=0. Then rsp_ready=1 returns 7, 8, 0, 0xFFFF_FFFF_FFFF_FFFF in order, with no loss or duplication.
- Full FIFO with simultaneous pop and push (count=2, rsp_ready=1, issue valid) → count stays 2, throughput is not interrupted.
- Word op: port 0 ADD, word=1, op1=0x7FFF_FFFF, op2=1 → rsp_data=0xFFFF_FFFF_8000_0000.
- Flush with 3 ops in flight and both requests valid → no ready that cycle, rsp_valid=0 next cycle, subsequent ops complete normally. Reset asserted mid-stream → all outputs 0, rr pointer=0.

Source files
------------

// File: rtl/exe_alu_arbiter.sv
// Round-robin share of the execute-stage ALU between two requesters.
// One issue register drives the ALU; results queue in a 2-entry response FIFO.
module exe_alu_arbiter #(
  parameter int XLEN  = 64,
  parameter int ALU_W = 10,
  parameter int BJ_W  = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_op1,
  input  logic [XLEN-1:0]  req0_op2,
  input  logic [ALU_W-1:0] req0_alu_info,
  input  logic             req0_word,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_op1,
  input  logic [XLEN-1:0]  req1_op2,
  input  logic [ALU_W-1:0] req1_alu_info,
  input  logic             req1_word,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [ALU_W-1:0] alu_info,
  output logic             alu_word,
  input  logic [XLEN-1:0]  alu_output,
  input  logic [BJ_W-1:0]  alu_bj,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [XLEN-1:0]  rsp_data,
  output logic [BJ_W-1:0]  rsp_bj
);

  logic             r_iss_valid;
  logic [XLEN-1:0]  r_iss_op1;
  logic [XLEN-1:0]  r_iss_op2;
  logic [ALU_W-1:0] r_iss_info;
  logic             r_iss_word;
  logic [TAG_W-1:0] r_iss_tag;
  logic             r_iss_id;

  logic [XLEN-1:0]  r_fifo_data [2];
  logic [BJ_W-1:0]  r_fifo_bj   [2];
  logic [TAG_W-1:0] r_fifo_tag  [2];
  logic             r_fifo_id   [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             r_rr;

  logic             w_pop;
  logic             w_adv;
  logic             w_free;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_slot_ok;
  logic             w_acc;
  logic             w_acc_id;

  assign rsp_valid = (r_count != 2'd0);
  assign w_pop     = rsp_valid & rsp_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_adv     = r_iss_valid & ((r_count != 2'd2) | w_pop);
  assign w_free    = ~r_iss_valid | w_adv;

  // Port 1 wins when alone or when both request and the pointer favours it.
  assign w_gnt1    = req1_valid & (~req0_valid | r_rr);
  assign w_gnt0    = req0_valid & ~w_gnt1;
  assign w_slot_ok = w_free & ~flush & rst;
  assign req0_ready = w_gnt0 & w_slot_ok;
  assign req1_ready = w_gnt1 & w_slot_ok;
  assign w_acc      = req0_ready | req1_ready;
  assign w_acc_id   = req1_ready;

  // Stage 0 -> 1: accepted request enters the issue register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_iss_valid <= 1'b0;
      r_iss_op1   <= '0;
      r_iss_op2   <= '0;
      r_iss_info  <= '0;
      r_iss_word  <= 1'b0;
      r_iss_tag   <= '0;
      r_iss_id    <= 1'b0;
      r_rr        <= 1'b0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_acc) begin
      r_iss_valid <= 1'b1;
      r_iss_op1   <= w_acc_id ? req1_op1      : req0_op1;
      r_iss_op2   <= w_acc_id ? req1_op2      : req0_op2;
      r_iss_info  <= w_acc_id ? req1_alu_info : req0_alu_info;
      r_iss_word  <= w_acc_id ? req1_word     : req0_word;
      r_iss_tag   <= w_acc_id ? req1_tag      : req0_tag;
      r_iss_id    <= w_acc_id;
      r_rr        <= ~w_acc_id;
    end else if (w_adv) begin
      r_iss_valid <= 1'b0;
    end
  end

  // Stage 1 -> 2: ALU result lands in the response FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_bj[i]   <= '0;
        r_fifo_tag[i]  <= '0;
        r_fifo_id[i]   <= 1'b0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_adv) begin
        r_fifo_data[r_wptr] <= alu_output;
        r_fifo_bj[r_wptr]   <= alu_bj;
        r_fifo_tag[r_wptr]  <= r_iss_tag;
        r_fifo_id[r_wptr]   <= r_iss_id;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_adv, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign alu_op1  = r_iss_op1;
  assign alu_op2  = r_iss_op2;
  assign alu_info = r_iss_valid ? r_iss_info : '0;
  assign alu_word = r_iss_word;

  assign rsp_id   = r_fifo_id[r_rptr];
  assign rsp_tag  = r_fifo_tag[r_rptr];
  assign rsp_data = r_fifo_data[r_rptr];
  assign rsp_bj   = r_fifo_bj[r_rptr];

endmodule
